iob_fp_div_rm: RTL and testbench
================================

# iob_fp_div_rm

Parametrised iterative IEEE-754 floating-point divider with a self-contained radix-2 restoring mantissa divider. Selectable per-operation rounding (round-to-nearest-even or round-toward-zero) and full exception flags: overflow, underflow, invalid, divide-by-zero and inexact. Special operands complete early. Sits in the iob_fp arithmetic library beside the other FP units, driven by a start/done/busy handshake.

## Interface
- DATA_W, 32: total word width (sign + exponent + fraction).
- EXP_W, 8: exponent width. F = DATA_W-EXP_W-1 fraction bits; BIAS = 2^(EXP_W-1)-1.
- clk_i  input  1  clock.
- rst_i  input  1  reset: one clock; reset is synchronous and active-high.
- start_i  input  1  start pulse; accepted only when busy_o=0.
- rnd_i  input  1  rounding mode, sampled with start_i: 0 = RNE, 1 = RTZ.
- op_a_i  input  DATA_W  dividend, sampled with start_i.
- op_b_i  input  DATA_W  divisor, sampled with start_i.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; res_o and flags valid from this cycle.
- res_o  output  DATA_W  result.
- overflow_o, underflow_o, invalid_o, div_zero_o, inexact_o  output  1 each  exception flags for the current result.

## Operation
- FSM states: IDLE, UNPACK, DIV, NORM, ROUND.
- IDLE + start_i: register operands and rnd_i, go to UNPACK, busy_o=1.
- UNPACK: classify registered operands. Subnormal inputs are treated as signed zero (flush).
- Special result written immediately, then return to IDLE with done_o pulse:
  - Either operand NaN → canonical NaN {0, all-ones exponent, 1, zeros}; no flag.
  - 0/0 or inf/inf → canonical NaN, invalid_o=1.
  - finite nonzero/0 → ±inf, div_zero_o=1.
  - 0/finite or finite/inf → ±0.
  - inf/finite → ±inf.
- Sign is always sa^sb, except for NaN.
- Normal path: exponent e = ea-eb+BIAS, computed in signed EXP_W+2 bits. Mantissas ma = {1,fa}, mb = {1,fb}.
- DIV: F+4 cycles, one quotient bit per cycle, MSB first. Q = floor(ma·2^(F+3)/mb), F+4 bits; rem_nz = remainder≠0.
- NORM:
  - If Q[F+3]=1: mantissa = Q[F+3:3], G=Q[2], R=Q[1], S=Q[0]|rem_nz.
  - Otherwise: mantissa = Q[F+2:2], G=Q[1], R=Q[0], S=rem_nz, e = e-1.
- ROUND:
  - inexact = G|R|S.
  - RNE: increment when G&(R|S|lsb). RTZ: never increment.
  - Mantissa carry-out → mantissa = 1.0, e = e+1.
  - Overflow, checked after rounding, when e ≥ 2^EXP_W-1:
    - RNE → ±inf; RTZ → ±max finite {exp=2^EXP_W-2, fraction all ones}.
    - overflow_o=1, inexact_o=1.
  - Underflow, when e ≤ 0 before rounding: result = signed zero, underflow_o=1, inexact_o=1.
  - Otherwise pack {sign, e[EXP_W-1:0], mantissa[F-1:0]}.
- Flags not raised by an operation are 0 in its result.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- Reset asserted mid-operation aborts it; no done_o pulse follows.
- Latency is counted in rising edges after the edge that samples start_i.
- Special operands: done_o is high in the cycle after edge 2.
- Normal operands: done_o is high in the cycle after edge F+7 (30 for 32/8, 59 for 64/11). Latency does not depend on data.
- busy_o rises the cycle after acceptance and falls in the same cycle done_o is high.
- start_i while busy_o=1 is ignored; no queueing.
- start_i in the done_o cycle is accepted, giving back-to-back operation.
- res_o and the flags hold their value until the next done_o. They do not change while busy.

## Test plan
- 0x3F800000 / 0x3F800000, RNE → 0x3F800000, all flags 0, done_o exactly 30 cycles after start.
- 0x3F800000 / 0x40400000 → RNE 0x3EAAAAAB, RTZ 0x3EAAAAAA, inexact_o=1 in both; 0x40C00000 / 0xC0000000 → 0xC0400000, inexact_o=0.
- 0x3F800000 / 0x00000000 → 0x7F800000, div_zero_o=1. 0x00000000 / 0x00000000 → 0x7FC00000, invalid_o=1. Both with done_o at 2 cycles.
- 0x7F000000 / 0x3F000000 → RNE 0x7F800000, RTZ 0x7F7FFFFF, overflow_o=1, inexact_o=1. 0x00800000 / 0x40000000 → 0x00000000, underflow_o=1, inexact_o=1.
- Back-to-back and busy handling:
  - start_i re-pulsed mid-operation is ignored: result and timing unchanged.
  - start_i in the done_o cycle gives the second done_o 30 cycles later.
- rst_i pulsed at cycle 10 of an operation → no done_o, outputs 0. A new start then completes normally.

Source files
------------

// File: rtl/iob_fp_div_rm.sv
// iob_fp_div_rm: iterative IEEE-754 divider with a radix-2 restoring mantissa divide,
// RNE/RTZ rounding and full exception flags; subnormal operands are flushed to zero.
module iob_fp_div_rm #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              rnd_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              invalid_o,
    output logic              div_zero_o,
    output logic              inexact_o
);
    localparam int F    = DATA_W - EXP_W - 1;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(F + 4);

    typedef enum logic [2:0] {IDLE, UNPACK, DIV, NORM, ROUND} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              rnd_q, g_q, r_q, s_q;
    logic              ovf_q, unf_q, inv_q, dz_q, inx_q, done_q;
    logic [EW-1:0]     exp_q;
    logic [F:0]        mb_q;
    logic [F+1:0]      rem_q;
    logic [F+3:0]      quo_q;
    logic [CW-1:0]     cnt_q;
    logic [F-1:0]      man_q;

    logic [EXP_W-1:0]  ea, eb;
    logic [F-1:0]      fa, fb, frac;
    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, any_nan;
    logic              special, sp_inv, sp_dz, ge, rem_nz, inc, cy, unf, ovf;
    logic [F:0]        diff;
    logic [EW-1:0]     e_r;
    logic [DATA_W-1:0] qnan, inf_w, zero_w, max_w, sp_res, n_res;

    // a_q/b_q are stable for the whole operation, so classification stays combinational
    assign ea      = a_q[DATA_W-2:F];
    assign eb      = b_q[DATA_W-2:F];
    assign fa      = a_q[F-1:0];
    assign fb      = b_q[F-1:0];
    assign sgn     = a_q[DATA_W-1] ^ b_q[DATA_W-1];
    assign a_nan   = (&ea) & (|fa);
    assign b_nan   = (&eb) & (|fb);
    assign a_inf   = (&ea) & ~(|fa);
    assign b_inf   = (&eb) & ~(|fb);
    assign a_zero  = ~(|ea);
    assign b_zero  = ~(|eb);
    assign any_nan = a_nan | b_nan;
    assign special = any_nan | a_inf | b_inf | a_zero | b_zero;
    assign sp_inv  = ~any_nan & ((a_zero & b_zero) | (a_inf & b_inf));
    assign sp_dz   = ~any_nan & b_zero & ~a_zero & ~a_inf;

    assign qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F-1){1'b0}}};
    assign inf_w  = {sgn, {EXP_W{1'b1}}, {F{1'b0}}};
    assign zero_w = {sgn, {(DATA_W-1){1'b0}}};
    assign max_w  = {sgn, {(EXP_W-1){1'b1}}, 1'b0, {F{1'b1}}};
    assign sp_res = (any_nan | sp_inv) ? qnan : (b_zero | a_inf) ? inf_w : zero_w;

    assign ge     = rem_q >= {1'b0, mb_q};
    assign diff   = (F+1)'(rem_q - (ge ? {1'b0, mb_q} : '0));
    assign rem_nz = |rem_q;

    assign inc       = ~rnd_q & g_q & (r_q | s_q | man_q[0]);
    assign {cy, frac} = {1'b0, man_q} + (F+1)'(inc);
    assign e_r       = exp_q + EW'(cy);
    assign unf       = exp_q[EW-1] | ~(|exp_q);
    assign ovf       = ~unf & (e_r >= EW'(2 ** EXP_W - 1));
    assign n_res     = unf ? zero_w : ovf ? (rnd_q ? max_w : inf_w) : {sgn, e_r[EXP_W-1:0], frac};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_i ? UNPACK : IDLE;
            UNPACK:  state_d = special ? ROUND : DIV;
            DIV:     state_d = (cnt_q == CW'(F + 3)) ? NORM : DIV;
            NORM:    state_d = ROUND;
            ROUND:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inv_q  <= 1'b0;
            dz_q   <= 1'b0;
            inx_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    a_q   <= op_a_i;
                    b_q   <= op_b_i;
                    rnd_q <= rnd_i;
                end
                UNPACK: begin
                    exp_q <= EW'(ea) - EW'(eb) + EW'(BIAS);
                    mb_q  <= {1'b1, fb};
                    rem_q <= {2'b01, fa};
                    quo_q <= '0;
                    cnt_q <= '0;
                end
                DIV: begin
                    rem_q <= {diff, 1'b0};
                    quo_q <= {quo_q[F+2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                end
                NORM: begin
                    man_q <= quo_q[F+3] ? quo_q[F+2:3] : quo_q[F+1:2];
                    g_q   <= quo_q[F+3] ? quo_q[2] : quo_q[1];
                    r_q   <= quo_q[F+3] ? quo_q[1] : quo_q[0];
                    s_q   <= (quo_q[F+3] & quo_q[0]) | rem_nz;
                    exp_q <= quo_q[F+3] ? exp_q : exp_q - 1'b1;
                end
                ROUND: begin
                    done_q <= 1'b1;
                    res_q  <= special ? sp_res : n_res;
                    ovf_q  <= ~special & ovf;
                    unf_q  <= ~special & unf;
                    inv_q  <= special & sp_inv;
                    dz_q   <= special & sp_dz;
                    inx_q  <= ~special & (g_q | r_q | s_q | unf | ovf);
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign res_o       = res_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
    assign invalid_o   = inv_q;
    assign div_zero_o  = dz_q;
    assign inexact_o   = inx_q;
endmodule

// File: tb/tb_iob_fp_div_rm.sv
// tb_iob_fp_div_rm: directed and randomized checks of iob_fp_div_rm (32/8) against
// an arithmetic reference model of the division and rounding rules.
module tb_iob_fp_div_rm;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rnd = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, res;
    logic        busy, done, ovf, unf, inv, dz, inx;
    logic [4:0]  flg;
    int          checks = 0, errors = 0;

    assign flg = {ovf, unf, inv, dz, inx};

    iob_fp_div_rm dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rnd_i(rnd),
        .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done), .res_o(res),
        .overflow_o(ovf), .underflow_o(unf), .invalid_o(inv), .div_zero_o(dz), .inexact_o(inx)
    );

    always #5 clk = ~clk;

    // returns {special, result, {ovf, unf, inv, dz, inx}}
    function automatic logic [37:0] model(input logic [31:0] a, input logic [31:0] b, input logic r);
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic s, an, bn, ai, bi, az, bz, st, up, ix;
        longint unsigned ma, mb, num, q, mant, low, half;
        int e, sh;
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        s  = a[31] ^ b[31];
        an = (ea == 8'hFF) && (fa != 0); bn = (eb == 8'hFF) && (fb != 0);
        ai = (ea == 8'hFF) && (fa == 0); bi = (eb == 8'hFF) && (fb == 0);
        az = (ea == 0); bz = (eb == 0);
        if (an || bn) return {1'b1, 32'h7FC00000, 5'b00000};
        if ((az && bz) || (ai && bi)) return {1'b1, 32'h7FC00000, 5'b00100};
        if (bz && !ai) return {1'b1, s, 31'h7F800000, 5'b00010};
        if (ai) return {1'b1, s, 31'h7F800000, 5'b00000};
        if (az || bi) return {1'b1, s, 31'd0, 5'b00000};
        ma  = 64'({1'b1, fa});
        mb  = 64'({1'b1, fb});
        num = ma << 38;
        q   = num / mb;
        st  = (num % mb) != 0;
        e   = int'(ea) - int'(eb) + 127;
        if (q >= (64'd1 << 38)) sh = 15;
        else begin sh = 14; e--; end
        mant = q >> sh;
        low  = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        ix   = (low != 0) || st;
        if (e <= 0) return {1'b0, s, 31'd0, 5'b01001};
        up   = !r && ((low > half) || (low == half && (st || mant[0])));
        mant = mant + 64'(up);
        if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e++; end
        if (e >= 255) return {1'b0, r ? {s, 31'h7F7FFFFF} : {s, 31'h7F800000}, 5'b10001};
        return {1'b0, s, 8'(e), 23'(mant), 4'b0000, ix};
    endfunction

    function automatic logic [31:0] rand_op();
        int c;
        logic [7:0] e;
        logic [22:0] f;
        c = $urandom_range(0, 15);
        f = (c == 1) ? 23'd0 : 23'($urandom);
        e = (c == 0) ? 8'd0 : (c == 2) ? 8'hFF : (c < 6) ? 8'($urandom_range(200, 254)) :
            (c < 9) ? 8'($urandom_range(1, 60)) : 8'($urandom_range(1, 254));
        return {1'($urandom), e, f};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic r, output int lat);
        op_a = a; op_b = b; rnd = r; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1 lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({res, flg, busy, done} !== 39'd0) begin
            errors++;
            $display("FAIL reset_state: got res=%h flags=%b busy=%b done=%b, want all 0", res, flg, busy, done);
        end
    endtask

    logic [31:0] da[9] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40C00000, 32'h3F800000,
                           32'h00000000, 32'h7F000000, 32'h7F000000, 32'h00800000};
    logic [31:0] db[9] = '{32'h3F800000, 32'h40400000, 32'h40400000, 32'hC0000000, 32'h00000000,
                           32'h00000000, 32'h3F000000, 32'h3F000000, 32'h40000000};
    logic        dr[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] dq[9] = '{32'h3F800000, 32'h3EAAAAAB, 32'h3EAAAAAA, 32'hC0400000, 32'h7F800000,
                           32'h7FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000000};
    logic [4:0]  df[9] = '{5'b00000, 5'b00001, 5'b00001, 5'b00000, 5'b00010,
                           5'b00100, 5'b10001, 5'b10001, 5'b01001};
    int          dl[9] = '{30, 30, 30, 30, 2, 2, 30, 30, 30};

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 9; i++) begin
            do_op(da[i], db[i], dr[i], lat);
            checks += 3;
            if (lat !== dl[i]) begin
                errors++;
                $display("FAIL directed%0d_latency: got %0d, want %0d", i, lat, dl[i]);
            end
            if (res !== dq[i]) begin
                errors++;
                $display("FAIL directed%0d_result: got %h, want %h", i, res, dq[i]);
            end
            if (flg !== df[i]) begin
                errors++;
                $display("FAIL directed%0d_flags: got %b, want %b", i, flg, df[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] a, b;
        logic r;
        logic [37:0] m;
        for (int i = 0; i < 200; i++) begin
            a = rand_op(); b = rand_op(); r = 1'($urandom);
            m = model(a, b, r);
            do_op(a, b, r, lat);
            checks++;
            if (lat !== (m[37] ? 2 : 30) || res !== m[36:5] || flg !== m[4:0]) begin
                errors++;
                $display("FAIL random%0d: %h/%h rnd=%b got res=%h flags=%b lat=%0d, want res=%h flags=%b lat=%0d",
                         i, a, b, r, res, flg, lat, m[36:5], m[4:0], m[37] ? 2 : 30);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [31:0] prev;
        prev = res;
        op_a = 32'h3F800000; op_b = 32'h40400000; rnd = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1 lat++;
            start = (lat == 5);
            if (lat == 5) begin op_a = $urandom; op_b = $urandom; rnd = 1'b1; end
            if (lat == 10) begin
                checks++;
                if (busy !== 1'b1 || res !== prev) begin
                    errors++;
                    $display("FAIL busy_hold: got busy=%b res=%h, want busy=1 res=%h", busy, res, prev);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (lat !== 30 || res !== 32'h3EAAAAAB || flg !== 5'b00001) begin
            errors++;
            $display("FAIL busy_ignore: got res=%h flags=%b lat=%0d, want 3eaaaaab 00001 30", res, flg, lat);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_queue: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int l1, l2;
        do_op(32'h40C00000, 32'hC0000000, 1'b0, l1);
        checks++;
        if (l1 !== 30 || done !== 1'b1 || res !== 32'hC0400000) begin
            errors++;
            $display("FAIL b2b_first: got res=%h lat=%0d done=%b, want c0400000 30 1", res, l1, done);
        end
        do_op(32'h3F800000, 32'h40400000, 1'b1, l2);
        checks++;
        if (l2 !== 30 || res !== 32'h3EAAAAAA || flg !== 5'b00001) begin
            errors++;
            $display("FAIL b2b_second: got res=%h flags=%b lat=%0d, want 3eaaaaaa 00001 30", res, flg, l2);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen;
        op_a = 32'h7F000000; op_b = 32'h3F000000; rnd = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++;
        if ({res, flg, busy, done} !== 39'd0) begin
            errors++;
            $display("FAIL abort_state: got res=%h flags=%b busy=%b done=%b, want all 0", res, flg, busy, done);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1 if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done pulse=%b, want 0", seen);
        end
        do_op(32'h7F000000, 32'h3F000000, 1'b1, lat);
        checks++;
        if (lat !== 30 || res !== 32'h7F7FFFFF || flg !== 5'b10001) begin
            errors++;
            $display("FAIL abort_restart: got res=%h flags=%b lat=%0d, want 7f7fffff 10001 30", res, flg, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
